multacc_seq: RTL and testbench

//  Sequencer for one shared multacc (signed a*b+p, sync clear, enable) in the interpolation path.
//  Per job: clears the accumulator, fetches `taps` sample/coef pairs from a 1-cycle-latency

---
 rtl/multacc_seq.sv | 128 ++++++++++++
 tb/tb_multacc_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multacc_seq.sv
// Sequencer for one shared signed MAC: clear, fetch T sample/coef pairs, round/shift/saturate.
// Latency: result valid T+3 cycles after the accept cycle; one job per T+4 cycles.
// Backpressure: result held on out_valid until out_ready; start ignored while busy.
module multacc_seq #(
    parameter int A_BITS   = 16,
    parameter int B_BITS   = 8,
    parameter int P_BITS   = 26,
    parameter int OUT_BITS = 16,
    parameter int MAX_TAPS = 8,
    parameter int IDX_BITS = $clog2(MAX_TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          taps,
    input  logic [4:0]          shift,
    output logic                busy,
    output logic                rd_en,
    output logic [IDX_BITS-1:0] rd_idx,
    input  logic [A_BITS-1:0]   sample_i,
    input  logic [B_BITS-1:0]   coef_i,
    output logic                mac_rst,
    output logic                mac_en,
    output logic [A_BITS-1:0]   mac_a,
    output logic [B_BITS-1:0]   mac_b,
    input  logic [P_BITS-1:0]   mac_p,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int TAP_W = 4;
    localparam int SUM_W = P_BITS + 1;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (OUT_BITS - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FETCH = 3'd2,
        LAST  = 3'd3,
        RND   = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t              state, state_n;
    logic [TAP_W-1:0]    t_r;
    logic [TAP_W-1:0]    t_eff;
    logic [4:0]          shift_r;
    logic [IDX_BITS-1:0] idx_r;
    logic                idx_last;

    logic signed [SUM_W-1:0] sum_ext, rnd_val, sum_rnd, sum_sh;
    logic [OUT_BITS-1:0]     sat_out;

    always_comb begin
        t_eff = taps;
        if (taps == '0)
            t_eff = TAP_W'(1);
        else if (taps > TAP_W'(MAX_TAPS))
            t_eff = TAP_W'(MAX_TAPS);
    end

    assign idx_last = (TAP_W'(idx_r) == (t_r - TAP_W'(1)));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = CLR;
            CLR:     state_n = (t_r > TAP_W'(1)) ? FETCH : LAST;
            FETCH:   if (idx_last) state_n = LAST;
            LAST:    state_n = RND;
            RND:     state_n = OUT;
            OUT:     if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Round half up, then arithmetic shift, in one extra bit of headroom.
    always_comb begin
        sum_ext = SUM_W'($signed(mac_p));
        rnd_val = '0;
        if (shift_r != 5'd0)
            rnd_val = SUM_W'(1) << (shift_r - 5'd1);
        sum_rnd = sum_ext + rnd_val;
        sum_sh  = sum_rnd >>> shift_r;
        if (sum_sh > SAT_HI)
            sat_out = {1'b0, {(OUT_BITS-1){1'b1}}};
        else if (sum_sh < SAT_LO)
            sat_out = {1'b1, {(OUT_BITS-1){1'b0}}};
        else
            sat_out = sum_sh[OUT_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            t_r      <= TAP_W'(1);
            shift_r  <= '0;
            idx_r    <= '0;
            out_data <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        t_r     <= t_eff;
                        shift_r <= shift;
                    end
                end
                CLR:     idx_r    <= IDX_BITS'(1);
                FETCH:   idx_r    <= idx_r + IDX_BITS'(1);
                RND:     out_data <= sat_out;
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign rd_en     = (state == CLR) || (state == FETCH);
    assign rd_idx    = (state == FETCH) ? idx_r : '0;
    assign mac_rst   = rst || (state == CLR);
    assign mac_en    = (state == FETCH) || (state == LAST);
    assign mac_a     = sample_i;
    assign mac_b     = coef_i;
    assign out_valid = (state == OUT);

endmodule

// File: tb/tb_multacc_seq.sv
// Bench for multacc_seq: behavioural MAC and 1-cycle buffer, table of jobs plus
// hand sequences for backpressure and mid-job reset.
module tb_multacc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  taps;
    logic [4:0]  shift;
    logic        busy;
    logic        rd_en;
    logic [2:0]  rd_idx;
    logic [15:0] sample_i;
    logic [7:0]  coef_i;
    logic        mac_rst;
    logic        mac_en;
    logic [15:0] mac_a;
    logic [7:0]  mac_b;
    logic [25:0] mac_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    multacc_seq dut (
        .clk(clk), .rst(rst), .start(start), .taps(taps), .shift(shift),
        .busy(busy), .rd_en(rd_en), .rd_idx(rd_idx),
        .sample_i(sample_i), .coef_i(coef_i),
        .mac_rst(mac_rst), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_p(mac_p), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Shared multacc: p <= rst ? 0 : en ? a*b+p : p
    logic signed [25:0] p_m;
    logic signed [25:0] prod;
    assign prod  = 26'($signed(mac_a)) * 26'($signed(mac_b));
    assign mac_p = p_m;
    always @(posedge clk) begin
        if (mac_rst)     p_m <= '0;
        else if (mac_en) p_m <= p_m + prod;
    end

    // Sample/coef buffer, 1-cycle read latency
    logic signed [15:0] buf_s [8];
    logic signed [7:0]  buf_c [8];
    initial begin
        sample_i = '0;
        coef_i   = '0;
    end
    always @(posedge clk) begin
        if (rd_en) begin
            sample_i <= buf_s[rd_idx];
            coef_i   <= buf_c[rd_idx];
        end
    end

    typedef struct packed {
        logic [3:0]         taps;
        logic [4:0]         shift;
        logic signed [15:0] exp_data;
        int                 exp_lat;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];
    int   vs  [NV][8];
    int   vc  [NV][8];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input int i);
        for (int k = 0; k < 8; k++) begin
            buf_s[k] = 16'(vs[i][k]);
            buf_c[k] = 8'(vc[i][k]);
        end
    endtask

    // Issue job i from IDLE; returns cycle index where out_valid first seen.
    task automatic launch(input int i, output int lat);
        load_vec(i);
        @(negedge clk);
        start = 1'b1;
        taps  = vec[i].taps;
        shift = vec[i].shift;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_job(input int i);
        int lat;
        launch(i, lat);
        chk($sformatf("v%0d latency", i), lat, vec[i].exp_lat);
        chk($sformatf("v%0d out_data", i), int'($signed(out_data)), int'(vec[i].exp_data));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d idle after handshake", i), int'({busy, out_valid}), 0);
    endtask

    initial begin
        int cf2 [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
        int lat;

        // v0: samples 1..8, coefs 1 -> 36
        vec[0] = '{taps: 4'd8, shift: 5'd0, exp_data: 16'sd36, exp_lat: 11};
        for (int k = 0; k < 8; k++) begin vs[0][k] = k + 1; vc[0][k] = 1; end
        // v1: samples 100, filter coefs, S=6400, (6400+32)>>>6 = 100
        vec[1] = '{taps: 4'd8, shift: 5'd6, exp_data: 16'sd100, exp_lat: 11};
        for (int k = 0; k < 8; k++) begin vs[1][k] = 100; vc[1][k] = cf2[k]; end
        // v2/v3: positive and negative saturation
        vec[2] = '{taps: 4'd8, shift: 5'd0, exp_data: 16'sd32767, exp_lat: 11};
        for (int k = 0; k < 8; k++) begin vs[2][k] = 32767; vc[2][k] = 127; end
        vec[3] = '{taps: 4'd8, shift: 5'd0, exp_data: -16'sd32768, exp_lat: 11};
        for (int k = 0; k < 8; k++) begin vs[3][k] = 32767; vc[3][k] = -128; end
        // v4/v5: taps=1 and taps=0 -> single tap, -7*9
        vec[4] = '{taps: 4'd1, shift: 5'd0, exp_data: -16'sd63, exp_lat: 4};
        vec[5] = '{taps: 4'd0, shift: 5'd0, exp_data: -16'sd63, exp_lat: 4};
        for (int k = 0; k < 8; k++) begin
            vs[4][k] = (k == 0) ? -7 : 1000; vc[4][k] = (k == 0) ? 9 : 3;
            vs[5][k] = vs[4][k];             vc[5][k] = vc[4][k];
        end
        // v6: taps=12 clamps to 8
        vec[6] = '{taps: 4'd12, shift: 5'd0, exp_data: 16'sd36, exp_lat: 11};
        for (int k = 0; k < 8; k++) begin vs[6][k] = k + 1; vc[6][k] = 1; end
        // v7: 10*2 - 20 + 30*3 = 90, (90+2)>>>2 = 23; tap 3 must not be read
        vec[7] = '{taps: 4'd3, shift: 5'd2, exp_data: 16'sd23, exp_lat: 6};
        for (int k = 0; k < 8; k++) begin vs[7][k] = 500; vc[7][k] = 50; end
        vs[7][0] = 10; vc[7][0] = 2; vs[7][1] = 20; vc[7][1] = -1; vs[7][2] = 30; vc[7][2] = 3;
        // v8: negative rounding, (-3+1)>>>1 = -1
        vec[8] = '{taps: 4'd1, shift: 5'd1, exp_data: -16'sd1, exp_lat: 4};
        for (int k = 0; k < 8; k++) begin vs[8][k] = -3; vc[8][k] = 1; end
        // v9: 2 taps, 1000*100 + 1000*100 = 200000, (200000+8)>>>4 = 12500
        vec[9] = '{taps: 4'd2, shift: 5'd4, exp_data: 16'sd12500, exp_lat: 5};
        for (int k = 0; k < 8; k++) begin vs[9][k] = 1000; vc[9][k] = 100; end

        rst = 1'b1; start = 1'b0; taps = '0; shift = '0; out_ready = 1'b0;
        load_vec(0);
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset rd_en", int'(rd_en), 0);
        chk("reset rd_idx", int'(rd_idx), 0);
        chk("reset mac_en", int'(mac_en), 0);
        chk("reset mac_rst", int'(mac_rst), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle mac_rst", int'(mac_rst), 0);

        for (int i = 0; i < NV; i++) run_job(i);

        // Backpressure: hold OUT for 5 cycles with start pulses that must be ignored
        launch(0, lat);
        chk("bp latency", lat, 11);
        for (int c = 0; c < 5; c++) begin
            start = (c % 2 == 0); taps = 4'd1; shift = 5'd3;
            @(negedge clk);
            chk($sformatf("bp c%0d out_data", c), int'($signed(out_data)), 36);
            chk($sformatf("bp c%0d busy/valid", c), int'({busy, out_valid}), 3);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp idle after handshake", int'(busy), 0);
        run_job(4);

        // Mid-job reset at FETCH k=3 (cycle 4), then rerun
        load_vec(0);
        @(negedge clk);
        start = 1'b1; taps = 4'd8; shift = 5'd0;
        @(negedge clk);
        start = 1'b0;
        chk("fetch cycle1 CLR rd_idx/rd_en/mac_rst", int'({rd_en, mac_rst, rd_idx}), 'b11_000);
        repeat (3) @(negedge clk);
        chk("fetch k3 rd_idx", int'(rd_idx), 3);
        chk("fetch k3 mac_en", int'(mac_en), 1);
        rst = 1'b1;
        #1;
        chk("midrst mac_rst", int'(mac_rst), 1);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst idle", int'({busy, out_valid, mac_en}), 0);
        chk("midrst acc cleared", int'(mac_p), 0);
        run_job(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
